// File: rtl/lut_neuron_pkg.sv
// Shared types and defaults for the reloadable LUT neuron controller.
// The state encoding, the default fan-in/output widths and the table depth
// helper live here so the controller and its table agree on sizing.
package lut_neuron_pkg;

    localparam int IN_BITS_DEF  = 8;
    localparam int OUT_BITS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Number of truth-table entries addressed by an in_bits-wide input.
    function automatic int lut_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// Truth table for one LUT neuron: distributed RAM with a synchronous write
// port and an asynchronous read port that feeds the controller's output
// register directly. Contents are intentionally not reset.
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int ADDR_W = IN_BITS_DEF,
    parameter int DATA_W = OUT_BITS_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = lut_depth(ADDR_W);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Table write, one entry per accepted config beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/lut_neuron_cfg_ctrl.sv
// Controller for one runtime-programmable LUT neuron.
// A cfg_start pulse loads the whole truth table from the config stream,
// after which the neuron answers a valid/ready input stream through a
// single registered output stage. A reload requested while running first
// drains the pending result so table writes never overlap inference reads.
// Optional build macro: LUT_PARITY_EN adds an even-parity bit per entry and
// a registered parity_err output that travels with out_data.
module lut_neuron_cfg_ctrl
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = IN_BITS_DEF,
    parameter int OUT_BITS = OUT_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                table_valid
`ifdef LUT_PARITY_EN
    ,
    output logic                parity_err
`endif
);

    localparam int DEPTH = lut_depth(IN_BITS);
    localparam logic [IN_BITS-1:0] LAST_ADDR = IN_BITS'(DEPTH - 1);
`ifdef LUT_PARITY_EN
    localparam int RAM_W = OUT_BITS + 1;
`else
    localparam int RAM_W = OUT_BITS;
`endif

    state_t                state_reg, state_next;
    logic [IN_BITS-1:0]    addr_reg, addr_next;
    logic                  cfg_done_reg;
    logic                  table_valid_reg;
    logic                  out_valid_reg;
    logic [OUT_BITS-1:0]   out_data_reg;

    logic                  wr_en;
    logic                  last_wr;
    logic                  accept;
    logic [RAM_W-1:0]      wr_word;
    logic [RAM_W-1:0]      rd_word;

    // A restart in LOAD takes priority over the entry presented that cycle.
    assign wr_en   = (state_reg == LOAD) && cfg_valid && !cfg_start;
    assign last_wr = wr_en && (addr_reg == LAST_ADDR);
    assign accept  = in_valid && in_ready;

`ifdef LUT_PARITY_EN
    // Even parity: stored bit makes the total number of ones even.
    assign wr_word = {^cfg_data, cfg_data};
`else
    assign wr_word = cfg_data;
`endif

    lut_neuron_ram #(
        .ADDR_W (IN_BITS),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (addr_reg),
        .wdata (wr_word),
        .raddr (in_data),
        .rdata (rd_word)
    );

    // State register and load address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    // Next-state and next-address logic.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        // The counter only advances on writes and wraps to 0 after the last
        // entry; any non-load state or a restart parks it at 0.
        if (wr_en) begin
            addr_next = addr_reg + IN_BITS'(1);
        end else if ((state_reg != LOAD) || cfg_start) begin
            addr_next = '0;
        end
        case (state_reg)
            IDLE:    if (cfg_start) state_next = LOAD;
            LOAD:    if (last_wr) state_next = RUN;
            RUN:     if (cfg_start) state_next = DRAIN;
            DRAIN:   if (!out_valid_reg) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        cfg_ready = (state_reg == LOAD);
        in_ready  = (state_reg == RUN) && !cfg_start &&
                    (!out_valid_reg || out_ready);
    end

    // Load-complete pulse and table-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_done_reg    <= 1'b0;
            table_valid_reg <= 1'b0;
        end else begin
            cfg_done_reg <= last_wr;
            if (last_wr) begin
                table_valid_reg <= 1'b1;
            end else if ((state_reg == RUN) && cfg_start) begin
                table_valid_reg <= 1'b0;
            end
        end
    end

    // Output register: load on accept, drop valid once consumed, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= rd_word[OUT_BITS-1:0];
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef LUT_PARITY_EN
    logic parity_err_reg;

    // Parity check result registered alongside the data it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_reg <= 1'b0;
        end else if (accept) begin
            parity_err_reg <= ^rd_word;
        end
    end

    assign parity_err = parity_err_reg;
`endif

    assign cfg_done    = cfg_done_reg;
    assign table_valid = table_valid_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;

endmodule

// File: tb/tb_lut_neuron_cfg_ctrl.sv
// Bench for lut_neuron_cfg_ctrl: directed vectors plus a scoreboard that
// pushes the model's table entry for every accepted input and compares it
// against every consumed result. Build with LUT_PARITY_EN to add the
// corrupted-parity sequence.
module tb_lut_neuron_cfg_ctrl;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_done;
    logic                in_valid;
    logic                in_ready;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;
    logic                table_valid;
`ifdef LUT_PARITY_EN
    logic                parity_err;
`endif

    lut_neuron_cfg_ctrl #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .cfg_done    (cfg_done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .table_valid (table_valid)
`ifdef LUT_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_BITS-1:0]  din;
        logic [OUT_BITS-1:0] dout;
    } vec_t;

    typedef struct packed {
        logic [OUT_BITS-1:0] d;
        logic                p;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_count = 0;
    exp_t sb_q[$];
    logic [OUT_BITS-1:0] tb_table   [256];
    logic                tb_corrupt [256];
    logic                hold_prev = 1'b0;
    logic [OUT_BITS-1:0] hold_data = '0;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard, hold-stability and cfg_done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("result out_data=%0h expected=%0h", out_data, e.d);
                    check("sb_data", 32'(out_data), 32'(e.d));
`ifdef LUT_PARITY_EN
                    check("sb_parity", 32'(parity_err), 32'(e.p));
`endif
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({tb_table[in_data], tb_corrupt[in_data]});
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            if (cfg_done) done_count++;
        end
    end

    // Streams 256 entries into a table already in LOAD; mode<0 means a[1:0].
    task automatic load_body(input int mode);
        for (int a = 0; a < 256; a++) begin
            logic [7:0] av;
            av = a[7:0];
            cfg_valid = 1'b1;
            cfg_data  = (mode < 0) ? av[1:0] : mode[1:0];
            tb_table[a] = cfg_data;
            @(negedge clk);
            check("cfg_done_early", 32'(cfg_done), 0);
            step();
        end
        cfg_valid = 1'b0;
        @(negedge clk);
        check("cfg_done_pulse", 32'(cfg_done), 1);
        check("table_valid_set", 32'(table_valid), 1);
        check("run_in_ready", 32'(in_ready), 1);
        check("run_cfg_ready", 32'(cfg_ready), 0);
        step();
        @(negedge clk);
        check("cfg_done_single", 32'(cfg_done), 0);
        step();
    endtask

    // Bounded wait for the controller to enter LOAD.
    task automatic wait_cfg_ready(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!cfg_ready && k < 10) begin
            step();
            @(negedge clk);
            k++;
        end
        check(name, 32'(cfg_ready), 1);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{din: 8'h00, dout: 2'd0};
        vecs[1] = '{din: 8'h41, dout: 2'd1};
        vecs[2] = '{din: 8'hFE, dout: 2'd2};
        vecs[3] = '{din: 8'h13, dout: 2'd3};
        vecs[4] = '{din: 8'hA6, dout: 2'd2};
        vecs[5] = '{din: 8'h7F, dout: 2'd3};
        vecs[6] = '{din: 8'h80, dout: 2'd0};
        for (int i = 0; i < 256; i++) begin
            tb_table[i]   = '0;
            tb_corrupt[i] = 1'b0;
        end

        // Reset with inference input already asserted.
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        step(); step();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_table_valid", 32'(table_valid), 0);
        check("rst_cfg_done", 32'(cfg_done), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 0);
            check("idle_cfg_ready", 32'(cfg_ready), 0);
            check("idle_out_valid", 32'(out_valid), 0);
            check("idle_table_valid", 32'(table_valid), 0);
            step();
        end
        in_valid = 1'b0;

        // First load: table[a] = a[1:0].
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        load_body(-1);
        check("done_count_1", 32'(done_count), 1);

        // Back-to-back vectors, latency 1.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            @(negedge clk);
            check("vec_in_ready", 32'(in_ready), 1);
            if (i > 0) begin
                check("vec_out_valid", 32'(out_valid), 1);
                check("vec_out_data", 32'(out_data), 32'(vecs[i-1].dout));
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("vec_last_valid", 32'(out_valid), 1);
        check("vec_last_data", 32'(out_data), 32'(vecs[6].dout));
        step();
        @(negedge clk);
        check("vec_idle_valid", 32'(out_valid), 0);
        step();

        // Backpressure with result 2'b11 pending.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h03;
        @(negedge clk);
        check("bp_first_ready", 32'(in_ready), 1);
        step();
        in_data = 8'h04;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_out_data", 32'(out_data), 3);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 1);
        check("bp_release_data", 32'(out_data), 3);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(out_valid), 1);
        check("bp_next_data", 32'(out_data), 0);
        step();
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 0);
        step();

        // Reload requested while a result is pending: drain first.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h07;
        @(negedge clk);
        check("drain_accept", 32'(in_ready), 1);
        step();
        in_data = 8'h08; cfg_start = 1'b1;
        @(negedge clk);
        check("drain_start_ready", 32'(in_ready), 0);
        step();
        cfg_start = 1'b0;
        @(negedge clk);
        check("drain_table_valid", 32'(table_valid), 0);
        check("drain_cfg_ready", 32'(cfg_ready), 0);
        check("drain_in_ready", 32'(in_ready), 0);
        check("drain_hold_data", 32'(out_data), 3);
        step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        @(negedge clk);
        check("drain_ignore_start", 32'(cfg_ready), 0);
        check("drain_still_valid", 32'(out_valid), 1);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        wait_cfg_ready("drain_to_load");

        // Partial load, restart at address 100, then full reload of 2'b10.
        for (int a = 0; a < 100; a++) begin
            logic [7:0] av;
            av = a[7:0];
            cfg_valid = 1'b1;
            cfg_data  = av[1:0];
            tb_table[a] = cfg_data;
            step();
        end
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 2'b01;
        @(negedge clk);
        check("restart_no_done", 32'(cfg_done), 0);
        step();
        cfg_start = 1'b0;
        load_body(2);
        check("done_count_2", 32'(done_count), 2);

        // Random traffic over the reloaded table.
        for (int i = 0; i < 60; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        @(negedge clk);
        check("rand_drained", 32'(out_valid), 0);
        step();

`ifdef LUT_PARITY_EN
        // Corrupt stored parity of entry 5 and read it back.
        dut.u_ram.mem_reg[5][OUT_BITS] = ~dut.u_ram.mem_reg[5][OUT_BITS];
        tb_corrupt[5] = 1'b1;
        in_valid = 1'b1; in_data = 8'h05;
        step();
        in_data = 8'h06;
        @(negedge clk);
        check("par_err_valid", 32'(out_valid), 1);
        check("par_err_set", 32'(parity_err), 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("par_ok_clear", 32'(parity_err), 0);
        check("par_ok_data", 32'(out_data), 2);
        step();
        step();
`endif

        // cfg_start in RUN blocks a simultaneous input.
        in_valid = 1'b1; in_data = 8'h55; cfg_start = 1'b1;
        @(negedge clk);
        check("start_blocks_input", 32'(in_ready), 0);
        step();
        cfg_start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("start_no_output", 32'(out_valid), 0);
        check("start_clears_valid", 32'(table_valid), 0);
        step();
        wait_cfg_ready("run_to_load");

        check("sb_empty", 32'(sb_q.size()), 0);
        check("done_count_final", 32'(done_count), 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
